// File: rtl/cnt_seq_ctrl.sv
// Burst sequencer for the W-bit event counter: loads a start value on an
// accepted start, steps the counter len times, with pause, abort, wrap flag
// and one-cycle done/aborted pulses. All outputs are registered.
module cnt_seq_ctrl #(
  parameter int unsigned W     = 3,
  parameter int unsigned LEN_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [W-1:0]     start_val,
  input  logic [LEN_W-1:0] len,
  input  logic             pause,
  input  logic             abort,
  output logic [W-1:0]     cnt,
  output logic             cnt_vld,
  output logic             busy,
  output logic             done,
  output logic             aborted,
  output logic             wrapped
);

  typedef enum logic [1:0] {StIdle, StRun, StHold, StDone} state_e;

  state_e           state_q, state_d;
  logic [W-1:0]     cnt_q, cnt_d;
  logic [LEN_W-1:0] rem_q, rem_d;
  logic             vld_q, vld_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             aborted_q, aborted_d;
  logic             wrapped_q, wrapped_d;

  // State and output registers; reset returns everything to idle with no pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      rem_q     <= '0;
      vld_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
      wrapped_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rem_q     <= rem_d;
      vld_q     <= vld_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      aborted_q <= aborted_d;
      wrapped_q <= wrapped_d;
    end
  end

  // Next-state logic; abort beats pause beats step.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (start) state_d = (len != '0) ? StRun : StDone;
      end
      StRun: begin
        if (abort)                        state_d = StIdle;
        else if (pause)                   state_d = StHold;
        else if (rem_q == LEN_W'(1))      state_d = StDone;
      end
      StHold: begin
        if (abort)       state_d = StIdle;
        else if (!pause) state_d = StRun;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Next values of the registered outputs and the remaining-step counter.
  always_comb begin
    cnt_d     = cnt_q;
    rem_d     = rem_q;
    vld_d     = vld_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    aborted_d = 1'b0;
    wrapped_d = wrapped_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          cnt_d     = start_val;
          rem_d     = len;
          wrapped_d = 1'b0;
          vld_d     = 1'b1;
          if (len != '0) busy_d = 1'b1;
          else           done_d = 1'b1;
        end
      end
      StRun: begin
        if (abort) begin
          aborted_d = 1'b1;
          vld_d     = 1'b0;
          busy_d    = 1'b0;
        end else if (pause) begin
          vld_d = 1'b0;
        end else begin
          cnt_d = cnt_q + 1'b1;
          rem_d = rem_q - 1'b1;
          if (cnt_q == '1) wrapped_d = 1'b1;
          if (rem_q == LEN_W'(1)) begin
            done_d = 1'b1;
            busy_d = 1'b0;
          end
        end
      end
      StHold: begin
        if (abort) begin
          aborted_d = 1'b1;
          vld_d     = 1'b0;
          busy_d    = 1'b0;
        end else if (!pause) begin
          // Re-validate the held value; the next step happens one edge later.
          vld_d = 1'b1;
        end
      end
      StDone: begin
        vld_d = 1'b0;
      end
      default: begin
        vld_d  = 1'b0;
        busy_d = 1'b0;
      end
    endcase
  end

  assign cnt     = cnt_q;
  assign cnt_vld = vld_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign aborted = aborted_q;
  assign wrapped = wrapped_q;

endmodule

// File: tb/tb_cnt_seq_ctrl.sv
// Testbench for cnt_seq_ctrl: vector table, directed corner sequences and a
// randomized run against a behavioural model.
module tb_cnt_seq_ctrl;

  localparam int W     = 3;
  localparam int LEN_W = 3;
  localparam int M     = 1 << W;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [W-1:0]     start_val;
  logic [LEN_W-1:0] len;
  logic             pause;
  logic             abort;
  logic [W-1:0]     cnt;
  logic             cnt_vld, busy, done, aborted, wrapped;

  int checks = 0;
  int errors = 0;

  cnt_seq_ctrl #(.W(W), .LEN_W(LEN_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .start_val (start_val),
    .len       (len),
    .pause     (pause),
    .abort     (abort),
    .cnt       (cnt),
    .cnt_vld   (cnt_vld),
    .busy      (busy),
    .done      (done),
    .aborted   (aborted),
    .wrapped   (wrapped)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit s; int sv; int ln; bit p; bit a;
    int c; bit v; bit b; bit d; bit ab; bit w;
  } vec_t;

  vec_t tbl[13];

  // Behavioural model: counter value, steps left and a few flags.
  int m_cnt, m_left;
  bit m_vld, m_busy, m_held, m_done, m_ab, m_wr;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input int c, input bit v, input bit b,
                         input bit d, input bit ab, input bit w);
    chk({tag, " cnt"}, int'(cnt), c);
    chk({tag, " cnt_vld"}, int'(cnt_vld), int'(v));
    chk({tag, " busy"}, int'(busy), int'(b));
    chk({tag, " done"}, int'(done), int'(d));
    chk({tag, " aborted"}, int'(aborted), int'(ab));
    chk({tag, " wrapped"}, int'(wrapped), int'(w));
  endtask

  task automatic drive(input bit s, input int sv, input int ln, input bit p, input bit a);
    start     = s;
    start_val = W'(sv);
    len       = LEN_W'(ln);
    pause     = p;
    abort     = a;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset;
    m_cnt = 0; m_left = 0;
    m_vld = 0; m_busy = 0; m_held = 0; m_done = 0; m_ab = 0; m_wr = 0;
  endtask

  task automatic model_step(input bit s, input int sv, input int ln, input bit p, input bit a);
    bit was_done;
    was_done = m_done;
    m_done   = 0;
    m_ab     = 0;
    if (was_done) begin
      m_vld = 0;
    end else if (!m_busy) begin
      if (s) begin
        m_cnt  = sv;
        m_left = ln;
        m_wr   = 0;
        m_vld  = 1;
        if (ln == 0) m_done = 1;
        else         m_busy = 1;
      end
    end else if (a) begin
      m_busy = 0; m_held = 0; m_vld = 0; m_ab = 1;
    end else if (m_held) begin
      if (!p) begin
        m_held = 0; m_vld = 1;
      end
    end else if (p) begin
      m_held = 1; m_vld = 0;
    end else begin
      if (m_cnt == M - 1) m_wr = 1;
      m_cnt  = (m_cnt + 1) % M;
      m_left = m_left - 1;
      if (m_left == 0) begin
        m_busy = 0; m_done = 1;
      end
    end
  endtask

  initial begin
    // Basic burst 0..3, wrap burst 6..1, zero-length burst with start in DONE.
    tbl[0]  = '{1, 0, 3, 0, 0,  0, 1, 1, 0, 0, 0};
    tbl[1]  = '{0, 0, 0, 0, 0,  1, 1, 1, 0, 0, 0};
    tbl[2]  = '{0, 0, 0, 0, 0,  2, 1, 1, 0, 0, 0};
    tbl[3]  = '{0, 0, 0, 0, 0,  3, 1, 0, 1, 0, 0};
    tbl[4]  = '{0, 0, 0, 0, 0,  3, 0, 0, 0, 0, 0};
    tbl[5]  = '{1, 6, 3, 0, 0,  6, 1, 1, 0, 0, 0};
    tbl[6]  = '{0, 0, 0, 0, 0,  7, 1, 1, 0, 0, 0};
    tbl[7]  = '{0, 0, 0, 0, 0,  0, 1, 1, 0, 0, 1};
    tbl[8]  = '{0, 0, 0, 0, 0,  1, 1, 0, 1, 0, 1};
    tbl[9]  = '{0, 0, 0, 0, 0,  1, 0, 0, 0, 0, 1};
    tbl[10] = '{1, 5, 0, 0, 0,  5, 1, 0, 1, 0, 0};
    tbl[11] = '{1, 2, 4, 0, 0,  5, 0, 0, 0, 0, 0};
    tbl[12] = '{0, 0, 0, 0, 0,  5, 0, 0, 0, 0, 0};

    rst = 1'b1;
    drive(0, 0, 0, 0, 0);
    #12;
    chk_all("reset", 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 13; i++) begin
      drive(tbl[i].s, tbl[i].sv, tbl[i].ln, tbl[i].p, tbl[i].a);
      tick();
      chk_all($sformatf("vec%0d", i), tbl[i].c, tbl[i].v, tbl[i].b, tbl[i].d, tbl[i].ab,
              tbl[i].w);
    end

    // Pause: two paused edges, release re-validates 2, then 3,4,5 with done.
    drive(1, 1, 4, 0, 0); tick(); chk_all("pause ld", 1, 1, 1, 0, 0, 0);
    drive(0, 0, 0, 0, 0); tick(); chk_all("pause s1", 2, 1, 1, 0, 0, 0);
    drive(0, 0, 0, 1, 0); tick(); chk_all("pause h1", 2, 0, 1, 0, 0, 0);
    tick();                       chk_all("pause h2", 2, 0, 1, 0, 0, 0);
    drive(0, 0, 0, 0, 0); tick(); chk_all("pause rel", 2, 1, 1, 0, 0, 0);
    tick();                       chk_all("pause s2", 3, 1, 1, 0, 0, 0);
    tick();                       chk_all("pause s3", 4, 1, 1, 0, 0, 0);
    tick();                       chk_all("pause dn", 5, 1, 0, 1, 0, 0);
    tick();                       chk_all("pause idle", 5, 0, 0, 0, 0, 0);

    // Abort at cnt=3 (pause also high: abort wins), then a normal restart.
    drive(1, 0, 7, 0, 0); tick();
    drive(0, 0, 0, 0, 0); tick(); tick(); tick();
    chk_all("abort pre", 3, 1, 1, 0, 0, 0);
    drive(0, 0, 0, 1, 1); tick(); chk_all("abort hit", 3, 0, 0, 0, 1, 0);
    drive(0, 0, 0, 0, 0); tick(); chk_all("abort idle", 3, 0, 0, 0, 0, 0);
    drive(1, 2, 1, 0, 0); tick(); chk_all("restart ld", 2, 1, 1, 0, 0, 0);
    drive(0, 0, 0, 0, 0); tick(); chk_all("restart dn", 3, 1, 0, 1, 0, 0);
    tick();

    // Start pulsed during a burst is ignored; final step completes normally.
    drive(1, 0, 2, 0, 0); tick(); chk_all("ign ld", 0, 1, 1, 0, 0, 0);
    drive(1, 7, 5, 0, 0); tick(); chk_all("ign s1", 1, 1, 1, 0, 0, 0);
    tick();                       chk_all("ign dn", 2, 1, 0, 1, 0, 0);
    drive(0, 0, 0, 0, 0); tick();

    // Asynchronous reset mid-burst, no done afterwards.
    drive(1, 0, 5, 0, 0); tick();
    drive(0, 0, 0, 0, 0); tick(); tick();
    chk_all("rst pre", 2, 1, 1, 0, 0, 0);
    #2 rst = 1'b1;
    #1 chk_all("rst async", 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk_all($sformatf("rst after%0d", i), 0, 0, 0, 0, 0, 0);
    end

    // Randomized run against the model.
    model_reset();
    for (int i = 0; i < 3000; i++) begin
      bit s, p, a;
      int sv, ln;
      s  = ($urandom_range(0, 99) < 30);
      p  = ($urandom_range(0, 99) < 20);
      a  = ($urandom_range(0, 99) < 5);
      sv = $urandom_range(0, M - 1);
      ln = $urandom_range(0, (1 << LEN_W) - 1);
      drive(s, sv, ln, p, a);
      tick();
      model_step(s, sv, ln, p, a);
      chk_all($sformatf("rnd%0d", i), m_cnt, m_vld, m_busy, m_done, m_ab, m_wr);
      chk($sformatf("rnd%0d done&aborted", i), int'(done & aborted), 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
